// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that lends one shared combinational ALU to NUM_REQ requesters,
// one transaction at a time, and returns the registered result tagged with the winner's id.
module alu_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*4-1:0]  req_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [DATA_W-1:0]     rsp_result,
    output logic                  rsp_err,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [3:0]            alu_control,
    input  logic [DATA_W-1:0]     alu_result,
    output logic                  busy,
    output logic [15:0]           done_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              err_q, err_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [3:0]        alu_ctrl_q, alu_ctrl_d;
    logic [15:0]       done_q, done_d;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [3:0]        grant_op;
    int                cand_idx;

    // First valid requester at or above ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(cand_idx);
            end
        end
        grant_op = req_op[grant_idx*4 +: 4];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            err_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= '0;
            done_q       <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            err_q        <= err_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_ctrl_q   <= alu_ctrl_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        err_d        = err_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_ctrl_d   = alu_ctrl_q;
        done_d       = done_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    alu_a_d    = req_a[grant_idx*DATA_W +: DATA_W];
                    alu_b_d    = req_b[grant_idx*DATA_W +: DATA_W];
                    alu_ctrl_d = grant_op;
                    id_d       = grant_idx;
                    err_d      = (grant_op > 4'b0110);
                    ptr_d      = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                // Illegal opcodes never leak whatever the ALU computes for them.
                rsp_result_d = err_q ? '0 : alu_result;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    done_d      = done_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && rst_n && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
        busy        = (state_q != IDLE);
        rsp_valid   = rsp_valid_q;
        rsp_id      = id_q;
        rsp_result  = rsp_result_q;
        rsp_err     = err_q;
        alu_a       = alu_a_q;
        alu_b       = alu_b_q;
        alu_control = alu_ctrl_q;
        done_count  = done_q;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 32-bit ALU between NUM_REQ requesters using round-robin arbitration.
- Each request carries operands a/b and a 4-bit ALU opcode; one transaction is in flight at a time.
- The block drives the ALU's a, b and alu_control inputs, registers its result, and returns it with the winning requester's index.
- It sits between the core's functional units and the single shared ALU instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 32, operand/result width; must match the ALU width
- ID_W, 2, width of requester index; equals ceil(log2(NUM_REQ))

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
- req_a  input  NUM_REQ*DATA_W  operand a; requester i at bits [i*DATA_W +: DATA_W]
- req_b  input  NUM_REQ*DATA_W  operand b, same packing
- req_op  input  NUM_REQ*4  opcode; requester i at [i*4 +: 4]
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response accept from consumer
- rsp_id  output  ID_W  index of requester that issued the response
- rsp_result  output  DATA_W  registered ALU result
- rsp_err  output  1  opcode was outside 0000..0110
- alu_a  output  DATA_W  to ALU a
- alu_b  output  DATA_W  to ALU b
- alu_control  output  4  to ALU alu_control
- alu_result  input  DATA_W  from ALU result (combinational)
- busy  output  1  high in any state other than IDLE
- done_count  output  16  completed-transaction counter

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State goes to IDLE; priority pointer goes to 0 (requester 0 is highest priority).
  - All outputs go to 0: rsp_valid, rsp_id, rsp_result, rsp_err, alu_a, alu_b, alu_control, done_count, busy.
  - req_ready is 0 while rst_n=0.
- The state machine has three states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is set, grant the first set bit searching from index ptr upward, wrapping modulo NUM_REQ.
  - req_ready[grant] is 1 combinationally in the same cycle; all other bits are 0.
  - On that edge, capture a, b and op into alu_a, alu_b and alu_control.
  - Set the granted id and err = (op > 4'b0110).
  - Set ptr = grant+1 mod NUM_REQ, then go to EXEC.
  - With no req_valid set, stay in IDLE and keep ptr unchanged.
- EXEC:
  - alu_* outputs are stable and the ALU settles combinationally.
  - On the edge, rsp_result <= alu_result. If err is set, rsp_result <= 0 regardless of alu_result.
  - Set rsp_valid <= 1 and go to RESP.
- RESP:
  - rsp_valid, rsp_id, rsp_result and rsp_err stay stable until rsp_ready=1.
  - On handshake: rsp_valid <= 0, done_count <= done_count+1 (wraps 0xFFFF->0), go to IDLE.
  - req_ready is 0 throughout EXEC and RESP.
- Latency and throughput:
  - Request accepted at edge T; rsp_valid is high from T+1 through T+2 onward, visible in the cycle after the EXEC edge, i.e. 2 cycles after accept.
  - Minimum issue interval is 3 cycles.
- alu_a, alu_b and alu_control hold the last captured values outside EXEC. They do not return to 0 except on reset.
- Requesters must hold req_valid and operands stable until req_ready. The block does not latch req_valid.
- Deasserting req_valid before grant is legal and simply drops that request from arbitration.
- Simultaneous requests: exactly one grant per IDLE cycle. Round-robin guarantees every persistently-valid requester is served within NUM_REQ grants.
- Reset mid-transaction in EXEC or RESP discards the transaction: no response and no done_count increment.
- The block performs no arithmetic itself. Opcode encodings are passed through unmodified: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU.

Test Plan:
- Reset check: hold rst_n=0 for 2 cycles with all req_valid=1 -> req_ready=0, rsp_valid=0, done_count=0, busy=0.
- Single ADD: requester 2 sends a=5, b=7, op=0000 with rsp_ready=1 -> req_ready=4'b0100 in accept cycle; 2 cycles later rsp_valid=1, rsp_id=2, rsp_result=12, rsp_err=0; done_count=1.
- Round-robin: all four requesters valid continuously -> grant order 0,1,2,3,0; each rsp_id matches its grant; issue interval 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles after SUB a=10, b=3 -> rsp_valid held, rsp_result=7 stable, req_ready=0, busy=1; releases on rsp_ready=1.
- Illegal opcode: op=4'b1010, a=1, b=1 -> rsp_err=1, rsp_result=0; the next legal request returns rsp_err=0.
- Mid-operation reset: rst_n=0 during RESP -> rsp_valid=0 next cycle, done_count=0, ptr=0 (requester 0 wins next contention).
